// File: rtl/muxn_pipe.sv
// N-way word selector feeding a two-entry head/skid output buffer.
// in_ready comes straight from the skid flop, so upstream sees no combinational path.
module muxn_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4,
  parameter int unsigned SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] din,
  input  logic [SELW-1:0]    sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   y,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               flush,
  output logic               sel_err,
  input  logic               err_clr
);

  if (SELW != $clog2(N)) begin : gen_bad_selw
    $error("muxn_pipe: SELW must equal $clog2(N)");
  end

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             head_vld_q, head_vld_d;
  logic             skid_vld_q, skid_vld_d;
  logic             sel_err_q, sel_err_d;

  logic [WIDTH-1:0] sel_word;
  logic             sel_oor;
  logic             xfer;
  logic             hand;

  // Out-of-range selects resolve to zero because no channel matches.
  always_comb begin
    sel_word = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (sel == SELW'(i)) begin
        sel_word = din[i*WIDTH +: WIDTH];
      end
    end
    sel_oor = (32'(sel) >= N);
  end

  assign in_ready  = ~skid_vld_q;
  assign out_valid = head_vld_q;
  assign y         = head_q;
  assign sel_err   = sel_err_q;

  assign xfer = in_valid & ~skid_vld_q;
  assign hand = head_vld_q & out_ready;

  always_comb begin
    head_d     = head_q;
    skid_d     = skid_q;
    head_vld_d = head_vld_q;
    skid_vld_d = skid_vld_q;
    sel_err_d  = sel_err_q;

    if (hand) begin
      if (skid_vld_q) begin
        head_d     = skid_q;
        skid_vld_d = 1'b0;
      end else begin
        head_vld_d = 1'b0;
      end
    end

    // A transfer can only occur with the skid empty, so the head is the target
    // whenever it is free or being drained this cycle.
    if (xfer) begin
      if (!head_vld_q || hand) begin
        head_d     = sel_word;
        head_vld_d = 1'b1;
      end else begin
        skid_d     = sel_word;
        skid_vld_d = 1'b1;
      end
    end

    if (flush) begin
      head_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end

    if (err_clr) begin
      sel_err_d = 1'b0;
    end
    if (xfer && sel_oor) begin
      sel_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      skid_q     <= '0;
      head_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      sel_err_q  <= 1'b0;
    end else begin
      head_q     <= head_d;
      skid_q     <= skid_d;
      head_vld_q <= head_vld_d;
      skid_vld_q <= skid_vld_d;
      sel_err_q  <= sel_err_d;
    end
  end

endmodule

// File: tb/tb_muxn_pipe.sv
// Drives an N=4 and an N=5 instance with shared stimulus and checks both against
// a queue-based scoreboard of expected words, occupancy and error flag.
module tb_muxn_pipe;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [5*W-1:0] din = '0;
  logic [2:0]     sel = '0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic           flush = 1'b0;
  logic           err_clr = 1'b0;

  logic           in_ready4, out_valid4, sel_err4;
  logic [W-1:0]   y4;
  logic           in_ready5, out_valid5, sel_err5;
  logic [W-1:0]   y5;

  logic [W-1:0]   q4[$];
  logic [W-1:0]   q5[$];
  logic           err5_m = 1'b0;
  int             n_checks = 0;
  int             n_pass = 0;

  always #5 clk = ~clk;

  muxn_pipe #(.WIDTH(W), .N(4), .SELW(2)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din[4*W-1:0]),
    .sel       (sel[1:0]),
    .in_valid  (in_valid),
    .in_ready  (in_ready4),
    .y         (y4),
    .out_valid (out_valid4),
    .out_ready (out_ready),
    .flush     (flush),
    .sel_err   (sel_err4),
    .err_clr   (err_clr)
  );

  muxn_pipe #(.WIDTH(W), .N(5), .SELW(3)) u_dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready5),
    .y         (y5),
    .out_valid (out_valid5),
    .out_ready (out_ready),
    .flush     (flush),
    .sel_err   (sel_err5),
    .err_clr   (err_clr)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] chan(input int i);
    return din[i*W +: W];
  endfunction

  task automatic rand_din();
    for (int i = 0; i < 5; i++) din[i*W +: W] = $urandom;
  endtask

  // Compare the current (mid-low-phase) outputs with the model, advance the model
  // by the edge that is about to happen, then move to the next falling edge.
  task automatic cycle();
    bit xfer, hand;
    check("ov4", {31'b0, out_valid4}, {31'b0, q4.size() > 0});
    check("ir4", {31'b0, in_ready4}, {31'b0, q4.size() < 2});
    check("err4", {31'b0, sel_err4}, 32'd0);
    check("ov5", {31'b0, out_valid5}, {31'b0, q5.size() > 0});
    check("ir5", {31'b0, in_ready5}, {31'b0, q5.size() < 2});
    check("err5", {31'b0, sel_err5}, {31'b0, err5_m});
    if (q4.size() > 0) check("y4", y4, q4[0]);
    if (q5.size() > 0) check("y5", y5, q5[0]);
    xfer = in_valid && (q4.size() < 2);
    hand = out_ready && (q4.size() > 0);
    if (flush) begin
      q4.delete();
      q5.delete();
    end else begin
      if (hand) begin
        void'(q4.pop_front());
        void'(q5.pop_front());
      end
      if (xfer) begin
        q4.push_back(chan(int'(sel) % 4));
        q5.push_back((sel < 3'd5) ? chan(int'(sel)) : '0);
      end
    end
    if (err_clr) err5_m = 1'b0;
    if (xfer && sel >= 3'd5) err5_m = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset asserted before any clock edge must act immediately.
    #1 rst_n = 1'b0;
    #1;
    check("rst_ov", {31'b0, out_valid4}, 32'd0);
    check("rst_y", y4, 32'd0);
    check("rst_ir", {31'b0, in_ready5}, 32'd1);
    check("rst_err", {31'b0, sel_err5}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic select, accepted on the first edge after reset release.
    rand_din();
    din[2*W +: W] = 32'hDEADBEEF;
    sel = 3'd2;
    in_valid = 1'b1;
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    check("basic_y", y4, 32'hDEADBEEF);
    check("basic_ov", {31'b0, out_valid4}, 32'd1);
    cycle();

    // Backpressure: A, B fill head and skid, C waits.
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rand_din();
      sel = 3'(k);
      in_valid = 1'b1;
      cycle();
    end
    check("bp_ir", {31'b0, in_ready4}, 32'd0);
    rand_din();
    sel = 3'd3;
    repeat (3) cycle();
    out_ready = 1'b1;
    repeat (2) cycle();
    in_valid = 1'b0;
    repeat (3) cycle();

    // Streaming with random selects.
    for (int k = 0; k < 100; k++) begin
      rand_din();
      sel = 3'($urandom_range(0, 7));
      in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    repeat (2) cycle();
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;

    // Out-of-range select on N=5.
    rand_din();
    sel = 3'd7;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    check("oor_y", y5, 32'd0);
    check("oor_err", {31'b0, sel_err5}, 32'd1);
    repeat (3) cycle();
    rand_din();
    sel = 3'd6;
    in_valid = 1'b1;
    err_clr = 1'b1;
    cycle();
    in_valid = 1'b0;
    err_clr = 1'b0;
    check("oor_setwins", {31'b0, sel_err5}, 32'd1);
    cycle();
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    check("oor_clr", {31'b0, sel_err5}, 32'd0);
    cycle();

    // Flush with both entries full and a word on offer.
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rand_din();
      sel = 3'(k + 1);
      in_valid = 1'b1;
      cycle();
    end
    rand_din();
    sel = 3'd1;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_ov", {31'b0, out_valid4}, 32'd0);
    check("fl_ir", {31'b0, in_ready4}, 32'd1);
    out_ready = 1'b1;
    repeat (3) cycle();

    // Asynchronous reset between edges with a full buffer and sel_err set.
    out_ready = 1'b0;
    rand_din();
    sel = 3'd7;
    in_valid = 1'b1;
    cycle();
    sel = 3'd3;
    cycle();
    in_valid = 1'b0;
    cycle();
    #2 rst_n = 1'b0;
    #1;
    check("ar_ov", {31'b0, out_valid5}, 32'd0);
    check("ar_y", y5, 32'd0);
    check("ar_err", {31'b0, sel_err5}, 32'd0);
    check("ar_ir", {31'b0, in_ready5}, 32'd1);
    q4.delete();
    q5.delete();
    err5_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    rand_din();
    sel = 3'd4;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (2) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/muxn_pipe.md
MUXN_PIPE -- requirements
Module: muxn_pipe

Interface
REQ-001 Parameter WIDTH, default 32, data width of each input channel and of the output, legal range 1..64.
REQ-002 Parameter N, default 4, number of input channels, legal range 2..16.
REQ-003 Parameter SELW, default $clog2(N), select width; a value other than $clog2(N) is illegal.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 din  input  N*WIDTH  packed channels; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 sel  input  SELW  channel select, sampled with in_valid.
REQ-008 in_valid  input  1  upstream has a word to offer.
REQ-009 in_ready  output  1  block can accept; transfer occurs when in_valid && in_ready.
REQ-010 y  output  WIDTH  selected word at the buffer head.
REQ-011 out_valid  output  1  y holds a valid word.
REQ-012 out_ready  input  1  downstream consumes; handoff occurs when out_valid && out_ready.
REQ-013 flush  input  1  synchronous discard of all buffered words.
REQ-014 sel_err  output  1  sticky flag for an out-of-range select.
REQ-015 err_clr  input  1  synchronous clear of sel_err.

Function
REQ-016 On a transfer, the block shall capture din[sel*WIDTH +: WIDTH] into a two-entry FIFO with a head register and a skid register.
REQ-017 Latency shall be 1 cycle: a word accepted into an empty buffer appears on y with out_valid=1 at the next rising edge.
REQ-018 in_ready shall equal NOT skid_valid, decoded from registers only, with no combinational path from out_ready or in_valid.
REQ-019 Head empty or consumed this cycle, skid empty: a transfer shall load the head directly.
REQ-020 Head occupied and not consumed: a transfer shall load the skid register, and in_ready shall be 0 on the next cycle.
REQ-021 Handoff with skid valid: skid shall move to the head, skid shall become empty, and any simultaneous transfer shall be impossible because in_ready=0.
REQ-022 Words shall leave in acceptance order; no word shall be lost or duplicated.
REQ-023 While out_valid=1 and out_ready=0, y shall hold stable.
REQ-024 Sustained throughput shall be 1 word per cycle when out_ready stays 1.
REQ-025 Transfer with sel >= N: the stored word shall be all zeros, it shall pass through the FIFO normally, and sel_err shall be 1 from the next edge.
REQ-026 sel_err shall stay 1 until an err_clr cycle; if err_clr and a new out-of-range transfer coincide, set wins.
REQ-027 flush=1: both entries shall be invalidated at the edge (out_valid=0, in_ready=1 next cycle), and a transfer or handoff in the same cycle shall be discarded.
REQ-028 flush shall not affect sel_err.
REQ-029 When N is a power of two, sel >= N is unreachable and sel_err shall stay 0.

Reset
REQ-030 rst_n low shall immediately and asynchronously force out_valid=0, y=0, skid_valid=0 (in_ready=1) and sel_err=0, regardless of clk.
REQ-031 Reset asserted mid-operation shall discard all buffered words, with no partial word visible after release.
REQ-032 The first transfer shall be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-033 Basic select: N=4, WIDTH=32, din ch2=0xDEADBEEF, sel=2, in_valid pulse, out_ready=1 -> next cycle y=0xDEADBEEF, out_valid=1.
REQ-034 Backpressure: out_ready=0, words A,B,C offered on consecutive cycles -> A in head, B in skid, in_ready=0 (C held); then out_ready=1 -> y order A,B,C, y stable while stalled.
REQ-035 Streaming: out_ready=1, 100 back-to-back words with random sel -> 100 outputs in order, in_ready never 0.
REQ-036 Out-of-range select: N=5, sel=7 -> y=0, sel_err=1 until err_clr; err_clr coinciding with a second sel=6 transfer -> sel_err stays 1.
REQ-037 Flush: head and skid full, flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, offered word not delivered.
REQ-038 Async reset: rst_n dropped between clock edges with buffer full -> out_valid=0, y=0, sel_err=0 before the next edge.
